systolic_result_collector: RTL and testbench

//  Output-side counterpart of the array feed path: captures skewed per-column results leaving the

---
 rtl/systolic_result_collector.sv | 112 +++++++++++
 tb/tb_systolic_result_collector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_collector.sv
// Collects skewed column results from a systolic array, requantises Q16.16 to Q8.8 and emits full rows.
// Optional RESULT_SAT_EN: saturate on requantisation instead of wrapping.
module systolic_result_collector #(
  parameter int N      = 4,
  parameter int ACC_W  = 32,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        in_valid,
  input  logic [N*ACC_W-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic [15:0]         out_row_idx,
  output logic                overflow,
  input  logic                clr_ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef RESULT_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX =
    (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);
`endif

  logic [PW-1:0]     wp [N];
  logic [PW-1:0]     rd;
  logic [N-1:0]      filled     [DEPTH];
  logic [N-1:0]      filled_nxt [DEPTH];
  logic [DATA_W-1:0] buffer [DEPTH][N];
  logic [N-1:0]      accept;
  logic [N-1:0]      drop;
  logic              pop;

  function automatic logic [DATA_W-1:0] conv(
    input logic [ACC_W-1:0] x
  );
    logic signed [ACC_W-1:0] sh;
    sh = $signed(x) >>> FRAC;
`ifdef RESULT_SAT_EN
    if (sh > SMAX)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (sh < SMIN)
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return DATA_W'(sh);
`else
    return DATA_W'(sh);
`endif
  endfunction

  assign out_valid = &filled[rd];
  assign pop       = out_valid && out_ready;

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++)
      out_data[j*DATA_W +: DATA_W] = buffer[rd][j];
  end

  // A pop frees slot rd before this cycle's captures are judged.
  always_comb begin
    accept     = '0;
    drop       = '0;
    filled_nxt = filled;
    if (pop)
      filled_nxt[rd] = '0;
    for (int j = 0; j < N; j++) begin
      accept[j] = in_valid[j] &&
        (!filled[wp[j]][j] || (pop && (wp[j] == rd)));
      drop[j]   = in_valid[j] && !accept[j];
      if (accept[j])
        filled_nxt[wp[j]][j] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd          <= '0;
      out_row_idx <= '0;
      overflow    <= 1'b0;
      for (int j = 0; j < N; j++)
        wp[j] <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        filled[d] <= '0;
        for (int j = 0; j < N; j++)
          buffer[d][j] <= '0;
      end
    end else begin
      filled <= filled_nxt;
      if (pop) begin
        rd          <= rd + 1'b1;
        out_row_idx <= out_row_idx + 16'd1;
      end
      for (int j = 0; j < N; j++) begin
        if (accept[j]) begin
          buffer[wp[j]][j] <= conv(in_data[j*ACC_W +: ACC_W]);
          wp[j]            <= wp[j] + 1'b1;
        end
      end
      if (|drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Scoreboard bench for systolic_result_collector: per-column queue model, decoupled monitor.
// Build with +define+RESULT_SAT_EN to check the saturating variant.
module tb_systolic_result_collector;

  localparam int N      = 4;
  localparam int ACC_W  = 32;
  localparam int DATA_W = 16;
  localparam int FRAC   = 8;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [N*DATA_W-1:0] d;
    logic [15:0]         idx;
  } row_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        in_valid;
  logic [N*ACC_W-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [N*DATA_W-1:0] out_data;
  logic [15:0]         out_row_idx;
  logic                overflow;
  logic                clr_ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;

  logic [DATA_W-1:0] mq [N][$];
  row_t              exp_q [$];
  int                nsb;
  logic [15:0]       m_idx;
  logic              m_ovf;

  systolic_result_collector #(
    .N(N), .ACC_W(ACC_W), .DATA_W(DATA_W),
    .FRAC(FRAC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row_idx(out_row_idx),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Requantisation from the arithmetic definition: floor(x / 2^FRAC).
  function automatic logic [DATA_W-1:0] mconv(logic [ACC_W-1:0] x);
    longint v;
    logic [63:0] u;
    v = longint'($signed(x));
    v = v >>> FRAC;
`ifdef RESULT_SAT_EN
    if (v > longint'(2**(DATA_W-1) - 1)) v = 2**(DATA_W-1) - 1;
    if (v < -longint'(2**(DATA_W-1)))    v = -(2**(DATA_W-1));
`endif
    u = v;
    return u[DATA_W-1:0];
  endfunction

  task automatic model_clear();
    for (int j = 0; j < N; j++) mq[j].delete();
    exp_q.delete();
    nsb   = 0;
    m_idx = '0;
    m_ovf = 1'b0;
  endtask

  // One clock: check state, drive, advance model, step to posedge+1.
  task automatic cycle(logic [N-1:0] iv, logic [N*ACC_W-1:0] d,
                       logic rdy, logic clr);
    bit pop, dr;
    row_t r;
    chk("out_valid", {63'd0, out_valid}, {63'd0, nsb > 0});
    chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    clr_ovf   = clr;
    pop = (nsb > 0) && rdy;
    dr  = 0;
    if (pop) begin
      for (int j = 0; j < N; j++) void'(mq[j].pop_front());
      nsb--;
      m_idx++;
    end
    for (int j = 0; j < N; j++)
      if (iv[j]) begin
        if (mq[j].size() < DEPTH)
          mq[j].push_back(mconv(d[j*ACC_W +: ACC_W]));
        else
          dr = 1;
      end
    if (dr) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    forever begin
      int cmin;
      cmin = mq[0].size();
      for (int j = 1; j < N; j++)
        if (mq[j].size() < cmin) cmin = mq[j].size();
      if (nsb >= cmin) break;
      for (int j = 0; j < N; j++)
        r.d[j*DATA_W +: DATA_W] = mq[j][nsb];
      r.idx = m_idx + 16'(nsb);
      exp_q.push_back(r);
      nsb++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, logic rdy);
    repeat (n) cycle('0, '0, rdy, 1'b0);
  endtask

  task automatic stream(int rows, logic rdy, bit rnd);
    logic [N-1:0] iv;
    logic [N*ACC_W-1:0] d;
    int r;
    for (int t = 0; t < rows + N - 1; t++) begin
      iv = '0;
      d  = '0;
      for (int j = 0; j < N; j++) begin
        r = t - j;
        if (r >= 0 && r < rows) begin
          iv[j] = 1'b1;
          d[j*ACC_W +: ACC_W] = rnd ? ACC_W'($urandom)
                                    : ACC_W'((r + 1) << 16);
        end
      end
      cycle(iv, d, rdy, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_row_idx", 64'(out_row_idx), 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    model_clear();
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_row: got idx %0h expected none",
                 out_row_idx);
      end else begin
        row_t e;
        e = exp_q.pop_front();
        chk("row_data", 64'(out_data), 64'(e.d));
        chk("row_idx", 64'(out_row_idx), 64'(e.idx));
      end
    end
  end

  initial begin
    logic [N*ACC_W-1:0] d;
    logic [DATA_W-1:0]  e0, e1;
    int p0;
    rst_n = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Conversion corner values, all columns in one cycle.
    d = {32'h0001_0000, 32'hFFFF_8000, 32'hFF7F_0000, 32'h0080_0000};
    cycle('1, d, 1'b0, 1'b0);
`ifdef RESULT_SAT_EN
    e0 = 16'h7FFF; e1 = 16'h8000;
`else
    e0 = 16'h8000; e1 = 16'h7F00;
`endif
    chk("conv_pos", 64'(out_data[0 +: 16]), 64'(e0));
    chk("conv_neg", 64'(out_data[16 +: 16]), 64'(e1));
    chk("conv_small", 64'(out_data[32 +: 16]), 64'h0000_FF80);
    chk("conv_one", 64'(out_data[48 +: 16]), 64'h0000_0100);
    idle(3, 1'b1);

    // Skewed fill with free-running consumer.
    stream(4, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Backpressure: fifth row must be dropped.
    stream(5, 1'b0, 1'b0);
    chk("ovf_after_bp", {63'd0, overflow}, 64'd1);
    p0 = n_pop;
    idle(8, 1'b1);
    chk("bp_rows_drained", 64'(n_pop - p0), 64'd4);

    // Sticky clear.
    cycle('0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", {63'd0, overflow}, 64'd0);

    // Same-slot hazard: capture into the slot being popped.
    stream(4, 1'b0, 1'b1);
    d = '0;
    d[0 +: ACC_W] = 32'h1234_5678;
    cycle(4'b0001, d, 1'b1, 1'b0);
    chk("hazard_no_ovf", {63'd0, overflow}, 64'd0);
    d = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0};
    cycle(4'b1110, d, 1'b0, 1'b0);
    idle(8, 1'b1);

    // Drop coincident with clr_ovf keeps overflow set.
    d = '0;
    d[0 +: ACC_W] = 32'h0005_0000;
    repeat (4) cycle(4'b0001, d, 1'b0, 1'b0);
    cycle(4'b0001, d, 1'b0, 1'b1);
    chk("ovf_drop_wins", {63'd0, overflow}, 64'd1);

    // Reset in the middle of a row.
    cycle(4'b0011, {4{32'h0007_0000}}, 1'b0, 1'b0);
    do_reset();
    stream(1, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] iv;
      iv = N'($urandom);
      for (int j = 0; j < N; j++)
        d[j*ACC_W +: ACC_W] = ACC_W'($urandom);
      cycle(iv, d, ($urandom_range(0, 3) != 0) ^ (i[6] & i[5]),
            $urandom_range(0, 19) == 0);
    end
    idle(10, 1'b1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
